// File: rtl/rp8_exint_pkg.sv
// rp8_exint_pkg: shared types and constants for the rp8 external interrupt
// controller (sense encodings, register strobe indices, bit-7 positions).
package rp8_exint_pkg;

    typedef enum logic [1:0] {
        ISC_LOW  = 2'b00,
        ISC_ANY  = 2'b01,
        ISC_FALL = 2'b10,
        ISC_RISE = 2'b11
    } isc_t;

    // Strobe bit positions within io_re / io_we
    localparam int REG_EICR  = 0;
    localparam int REG_EIMSK = 1;
    localparam int REG_EIFR  = 2;
    localparam int REG_PCMSK = 3;

    // Pin-change enable lives in EIMSK bit 7, its flag in EIFR bit 7
    localparam int PCIE_BIT = 7;
    localparam int PCIF_BIT = 7;

    // True when the observed edge qualifies under the given sense mode.
    // Level mode never produces an edge hit.
    function automatic logic edge_hit(input isc_t isc, input logic rise, input logic fall);
        case (isc)
            ISC_ANY:  edge_hit = rise | fall;
            ISC_FALL: edge_hit = fall;
            ISC_RISE: edge_hit = rise;
            default:  edge_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rp8_exint_edge.sv
// rp8_exint_edge: registers the previous pin values and reports per-bit
// rising/falling edges. Detection is held off until the arm bit has set on the
// first clock after reset, so pins that are already high at reset do not look
// like fresh edges against the zeroed history.
module rp8_exint_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pin,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] prev;
    logic         arm;

    // Pin history and arm bit; arm stays 1 until the next reset
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            arm  <= 1'b0;
        end else begin
            prev <= pin;
            arm  <= 1'b1;
        end
    end

    assign rise = {W{arm}} &  pin & ~prev;
    assign fall = {W{arm}} & ~pin &  prev;

endmodule

// File: rtl/rp8_exint.sv
// rp8_exint: external interrupt controller for the rp8 core.
// INW sense-configurable INTn lines plus one pin-change interrupt over a
// PDW-wide port. The pin-change block is built only when the macro
// RP8_EXINT_PCINT_EN is defined; otherwise PCMSK/PCIE/PCIF read 0 and
// irq[INW] is tied low.
module rp8_exint #(
    parameter int          INW = 2,
    parameter int          PDW = 8,
    parameter logic [5:0]  ADR = 6'h00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     io_re,
    input  logic [3:0]     io_we,
    input  logic [7:0]     io_dw,
    output logic [7:0]     io_dr,
    input  logic [INW-1:0] ext_pin,
    input  logic [PDW-1:0] pc_pin,
    output logic [INW:0]   irq,
    input  logic [INW:0]   irq_ack
);

    import rp8_exint_pkg::*;

    // Register addressing is decoded upstream into io_re/io_we; ADR only has
    // to leave room for the four consecutive registers.
    if (INW < 1 || INW > 4 || PDW < 1 || PDW > 8 || ADR > 6'd60) begin : g_bad_param
        $error("rp8_exint: parameter out of range");
    end

    logic [2*INW-1:0] eicr;
    logic [INW-1:0]   eimsk;
    logic [INW-1:0]   intf;
    logic [INW-1:0]   intf_next;
    logic [INW-1:0]   level;
    logic [INW-1:0]   irq_ext;
    logic [INW-1:0]   ext_rise;
    logic [INW-1:0]   ext_fall;
    logic             pcie;
    logic             pcif;
    logic [PDW-1:0]   pcmsk;
    logic             irq_pc;
    logic             unused;

    rp8_exint_edge #(.W(INW)) u_ext_edge (
        .clk  (clk),
        .rst  (rst),
        .pin  (ext_pin),
        .rise (ext_rise),
        .fall (ext_fall)
    );

    // Configuration registers: EICR sense fields and EIMSK line enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eicr  <= '0;
            eimsk <= '0;
        end else begin
            if (io_we[REG_EICR])  eicr  <= io_dw[2*INW-1:0];
            if (io_we[REG_EIMSK]) eimsk <= io_dw[INW-1:0];
        end
    end

    // INTn flag update: level mode pins the flag low, a qualifying edge sets
    // it, and only then does a write-1 or acknowledge clear it (set wins)
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        intf_next = intf;
        level     = '0;
        irq_ext   = '0;
        for (int n = 0; n < INW; n++) begin
            level[n] = (isc_t'(eicr[2*n +: 2]) == ISC_LOW);
            if (level[n]) begin
                intf_next[n] = 1'b0;
                irq_ext[n]   = eimsk[n] & ~ext_pin[n];
            end else begin
                if (edge_hit(isc_t'(eicr[2*n +: 2]), ext_rise[n], ext_fall[n]))
                    intf_next[n] = 1'b1;
                else if ((io_we[REG_EIFR] & io_dw[n]) | irq_ack[n])
                    intf_next[n] = 1'b0;
                irq_ext[n] = eimsk[n] & intf[n];
            end
        end
    end

    // INTn flag storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) intf <= '0;
        else     intf <= intf_next;
    end

`ifdef RP8_EXINT_PCINT_EN
    logic [PDW-1:0] pc_rise;
    logic [PDW-1:0] pc_fall;

    rp8_exint_edge #(.W(PDW)) u_pc_edge (
        .clk  (clk),
        .rst  (rst),
        .pin  (pc_pin),
        .rise (pc_rise),
        .fall (pc_fall)
    );

    // Pin-change mask, enable and flag; a masked change beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcmsk <= '0;
            pcie  <= 1'b0;
            pcif  <= 1'b0;
        end else begin
            if (io_we[REG_PCMSK]) pcmsk <= io_dw[PDW-1:0];
            if (io_we[REG_EIMSK]) pcie  <= io_dw[PCIE_BIT];
            if (|((pc_rise | pc_fall) & pcmsk))
                pcif <= 1'b1;
            else if ((io_we[REG_EIFR] & io_dw[PCIF_BIT]) | irq_ack[INW])
                pcif <= 1'b0;
        end
    end

    assign irq_pc = pcie & pcif;
`else
    assign pcmsk  = '0;
    assign pcie   = 1'b0;
    assign pcif   = 1'b0;
    assign irq_pc = 1'b0;
`endif

    // Inputs that a given build or parameter set may leave partly unread
    assign unused = ^{io_dw, irq_ack, pc_pin};

    assign irq = {irq_pc, irq_ext};

    // Read mux: a register is visible only for a single one-hot read strobe
    always_comb begin
        io_dr = 8'h00;
        case (io_re)
            4'b0001: io_dr = 8'(eicr);
            4'b0010: io_dr = {pcie, 7'(eimsk)};
            4'b0100: io_dr = {pcif, 7'(intf)};
            4'b1000: io_dr = 8'(pcmsk);
            default: io_dr = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rp8_exint.sv
// tb_rp8_exint: scoreboard bench for rp8_exint. Stimulus drives inputs just
// after each rising edge and queues the expected io_dr/irq for that cycle; a
// monitor samples the DUT on the falling edge and compares against the queue.
// Pin-change expectations follow RP8_EXINT_PCINT_EN.
module tb_rp8_exint;

    localparam int INW = 2;
    localparam int PDW = 8;

`ifdef RP8_EXINT_PCINT_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    localparam logic [3:0] R_NONE  = 4'b0000;
    localparam logic [3:0] R_EICR  = 4'b0001;
    localparam logic [3:0] R_EIMSK = 4'b0010;
    localparam logic [3:0] R_EIFR  = 4'b0100;
    localparam logic [3:0] R_PCMSK = 4'b1000;

    localparam int W_EICR  = 0;
    localparam int W_EIMSK = 1;
    localparam int W_EIFR  = 2;
    localparam int W_PCMSK = 3;

    logic           clk;
    logic           rst;
    logic [3:0]     io_re;
    logic [3:0]     io_we;
    logic [7:0]     io_dw;
    logic [7:0]     io_dr;
    logic [INW-1:0] ext_pin;
    logic [PDW-1:0] pc_pin;
    logic [INW:0]   irq;
    logic [INW:0]   irq_ack;

    typedef struct {
        string        name;
        logic [7:0]   dr;
        logic [INW:0] irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    rp8_exint #(.INW(INW), .PDW(PDW), .ADR(6'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_re   (io_re),
        .io_we   (io_we),
        .io_dw   (io_dw),
        .io_dr   (io_dr),
        .ext_pin (ext_pin),
        .pc_pin  (pc_pin),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected outputs for the current cycle, hold the read strobe
    // through the mid-cycle sample, then move past the next rising edge.
    task automatic chk(input string name, input logic [3:0] re,
                       input logic [7:0] dr, input logic [INW:0] irq_exp);
        exp_t e;
        e.name = name;
        e.dr   = dr;
        e.irq  = irq_exp;
        io_re  = re;
        exp_q.push_back(e);
        step();
        io_re  = '0;
    endtask

    task automatic wr(input int idx, input logic [7:0] d);
        io_we      = '0;
        io_we[idx] = 1'b1;
        io_dw      = d;
        step();
        io_we      = '0;
        io_dw      = '0;
    endtask

    // Monitor: compare outputs against the oldest expectation each mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (io_dr === mon_e.dr) n_pass++;
                else $display("FAIL %s io_dr: got %h, want %h", mon_e.name, io_dr, mon_e.dr);
                n_checks++;
                if (irq === mon_e.irq) n_pass++;
                else $display("FAIL %s irq: got %b, want %b", mon_e.name, irq, mon_e.irq);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        io_re   = '0;
        io_we   = '0;
        io_dw   = '0;
        ext_pin = 2'b11;
        pc_pin  = '0;
        irq_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values, pins already high
        chk("rst_eicr",  R_EICR,  8'h00, 3'b000);
        chk("rst_eimsk", R_EIMSK, 8'h00, 3'b000);
        chk("rst_eifr",  R_EIFR,  8'h00, 3'b000);
        chk("rst_pcmsk", R_PCMSK, 8'h00, 3'b000);

        // Rising sense on both lines with high pins: nothing may fire
        wr(W_EICR, 8'h0F);
        wr(W_EIMSK, 8'h03);
        chk("arm_eifr0", R_EIFR,  8'h00, 3'b000);
        chk("arm_eifr1", R_EIFR,  8'h00, 3'b000);
        chk("arm_eicr",  R_EICR,  8'h0F, 3'b000);
        chk("arm_eimsk", R_EIMSK, 8'h03, 3'b000);
        chk("multi_re",  4'b0011, 8'h00, 3'b000);
        chk("no_re",     R_NONE,  8'h00, 3'b000);

        // Falling edge on INT0, then acknowledge
        wr(W_EIMSK, 8'h01);
        wr(W_EICR, 8'h02);
        chk("fall_cfg", R_EICR, 8'h02, 3'b000);
        ext_pin = 2'b10;
        chk("fall_pre", R_EIFR, 8'h00, 3'b000);
        chk("fall_set", R_EIFR, 8'h01, 3'b001);
        irq_ack = 3'b001;
        chk("ack_pre",  R_EIFR, 8'h01, 3'b001);
        irq_ack = '0;
        chk("ack_clr",  R_EIFR, 8'h00, 3'b000);

        // Level mode on INT1
        wr(W_EIMSK, 8'h02);
        ext_pin = 2'b00;
        chk("lvl_low",  R_EIFR, 8'h00, 3'b010);
        irq_ack = 3'b010;
        chk("lvl_ack",  R_EIFR, 8'h00, 3'b010);
        irq_ack = '0;
        chk("lvl_hold", R_EIFR, 8'h00, 3'b010);
        ext_pin = 2'b10;
        chk("lvl_high", R_EIFR, 8'h00, 3'b000);

        // Any-edge on INT0 while masked, then unmask and clear
        wr(W_EIMSK, 8'h00);
        wr(W_EICR, 8'h01);
        ext_pin = 2'b11;
        chk("any_pre",     R_EIFR, 8'h00, 3'b000);
        chk("any_rise",    R_EIFR, 8'h01, 3'b000);
        wr(W_EIFR, 8'h00);
        chk("w0_keep",     R_EIFR, 8'h01, 3'b000);
        wr(W_EIMSK, 8'h01);
        chk("any_unmask",  R_EIFR, 8'h01, 3'b001);
        wr(W_EIFR, 8'h01);
        chk("w1_clr",      R_EIFR, 8'h00, 3'b000);
        ext_pin = 2'b10;
        chk("anyf_pre",    R_EIFR, 8'h00, 3'b000);
        chk("any_fall",    R_EIFR, 8'h01, 3'b001);
        wr(W_EIFR, 8'h01);
        chk("anyf_clr",    R_EIFR, 8'h00, 3'b000);

        // New edge in the same cycle as acknowledge / write-1 clear
        ext_pin = 2'b11;
        chk("race_pre",  R_EIFR, 8'h00, 3'b000);
        chk("race_set",  R_EIFR, 8'h01, 3'b001);
        ext_pin = 2'b10;
        irq_ack = 3'b001;
        chk("race_ack",  R_EIFR, 8'h01, 3'b001);
        irq_ack = '0;
        chk("race_keep", R_EIFR, 8'h01, 3'b001);
        ext_pin = 2'b11;
        wr(W_EIFR, 8'h01);
        chk("wrace_keep", R_EIFR, 8'h01, 3'b001);
        wr(W_EIFR, 8'h01);
        chk("wrace_clr",  R_EIFR, 8'h00, 3'b000);

        // Rising sense ignores a falling edge
        wr(W_EICR, 8'h03);
        ext_pin = 2'b10;
        chk("rise_fpre", R_EIFR, 8'h00, 3'b000);
        chk("rise_fign", R_EIFR, 8'h00, 3'b000);
        ext_pin = 2'b11;
        chk("rise_pre",  R_EIFR, 8'h00, 3'b000);
        chk("rise_set",  R_EIFR, 8'h01, 3'b001);
        wr(W_EIFR, 8'h01);

        // Pin-change interrupt on pin 4 only
        wr(W_PCMSK, 8'h10);
        wr(W_EIMSK, 8'h81);
        chk("pc_msk", R_PCMSK, PC ? 8'h10 : 8'h00, 3'b000);
        chk("pc_ie",  R_EIMSK, PC ? 8'h81 : 8'h01, 3'b000);
        pc_pin = 8'h08;
        chk("pc3_pre",   R_EIFR, 8'h00, 3'b000);
        chk("pc3_none",  R_EIFR, 8'h00, 3'b000);
        pc_pin = 8'h18;
        chk("pc4_pre",   R_EIFR, 8'h00, 3'b000);
        chk("pc4_set",   R_EIFR, PC ? 8'h80 : 8'h00, PC ? 3'b100 : 3'b000);
        irq_ack = 3'b100;
        chk("pc_ackpre", R_EIFR, PC ? 8'h80 : 8'h00, PC ? 3'b100 : 3'b000);
        irq_ack = '0;
        chk("pc_ackclr", R_EIFR, 8'h00, 3'b000);
        pc_pin = 8'h08;
        chk("pc_fpre",   R_EIFR, 8'h00, 3'b000);
        chk("pc_fset",   R_EIFR, PC ? 8'h80 : 8'h00, PC ? 3'b100 : 3'b000);
        wr(W_EIFR, 8'h80);
        chk("pc_wclr",   R_EIFR, 8'h00, 3'b000);

        // Unimplemented EIMSK bits read 0
        wr(W_EIMSK, 8'hFF);
        chk("eimsk_ff", R_EIMSK, PC ? 8'h83 : 8'h03, 3'b000);

        // Flag pending, then asynchronous reset mid-operation
        ext_pin = 2'b10;
        step();
        ext_pin = 2'b11;
        chk("pre_rst_pre", R_EIFR, 8'h00, 3'b000);
        chk("pre_rst_set", R_EIFR, 8'h01, 3'b001);
        rst = 1'b1;
        chk("mid_rst_eifr",  R_EIFR,  8'h00, 3'b000);
        chk("mid_rst_eimsk", R_EIMSK, 8'h00, 3'b000);
        rst = 1'b0;
        chk("post_rst_eicr", R_EICR,  8'h00, 3'b000);

        repeat (2) step();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
